// File: rtl/mesi_isc_breq_arb.sv
// Round-robin arbiter that moves one head entry per grant from the four CPU
// broadcast-request FIFOs into the shared broadcast FIFO, tagging it with cpu and broadcast id.
//
// state | meaning
// IDLE  | sample FIFO heads, pick the round-robin winner, latch its entry
// ISSUE | pop the winner's FIFO, write the broadcast FIFO unless the entry is a NOP
module mesi_isc_breq_arb #(
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    breq_fifo_empty_array_i,
  input  logic [4*BROAD_TYPE_WIDTH-1:0] breq_type_array_i,
  input  logic [4*ADDR_WIDTH-1:0]       breq_addr_array_i,
  input  logic                          broad_fifo_full_i,
  output logic [3:0]                    breq_fifo_rd_array_o,
  output logic                          broad_fifo_wr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
  output logic [ADDR_WIDTH-1:0]         broad_addr_o,
  output logic [1:0]                    broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_id_o
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(2);

  state_t                        r_state;
  state_t                        w_next_state;
  logic [1:0]                    r_last_grant;
  logic [1:0]                    r_winner;
  logic [BROAD_TYPE_WIDTH-1:0]   r_type;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic                          r_discard;
  logic [BROAD_ID_WIDTH-1:0]     r_id_cnt;

  logic                          w_found;
  logic [1:0]                    w_win;
  logic [BROAD_TYPE_WIDTH-1:0]   w_win_type;
  logic [ADDR_WIDTH-1:0]         w_win_addr;
  logic                          w_win_nop;
  logic                          w_grant;

  // Search starts just after the last grant so every CPU is reached within four grants.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && !breq_fifo_empty_array_i[r_last_grant + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_last_grant + 2'(k);
      end
    end
  end

  assign w_win_type = breq_type_array_i[w_win*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
  assign w_win_addr = breq_addr_array_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_nop  = (w_win_type != TYPE_WR) && (w_win_type != TYPE_RD);
  // A NOP head is drained even when the broadcast FIFO is full; it writes nothing.
  assign w_grant    = (r_state == IDLE) && w_found && (w_win_nop || !broad_fifo_full_i);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next_state = ISSUE;
      ISSUE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= 2'd3;
      r_winner     <= 2'd0;
      r_type       <= '0;
      r_addr       <= '0;
      r_discard    <= 1'b0;
      r_id_cnt     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_winner  <= w_win;
        r_type    <= w_win_type;
        r_addr    <= w_win_addr;
        r_discard <= w_win_nop;
      end
      if (r_state == ISSUE) begin
        r_last_grant <= r_winner;
        if (!r_discard) r_id_cnt <= r_id_cnt + 1'b1;
      end
    end
  end

  assign breq_fifo_rd_array_o = (r_state == ISSUE) ? (4'b0001 << r_winner) : 4'b0000;
  assign broad_fifo_wr_o      = (r_state == ISSUE) && !r_discard;
  assign broad_type_o         = r_type;
  assign broad_addr_o         = r_addr;
  assign broad_cpu_id_o       = r_winner;
  assign broad_id_o           = r_id_cnt;

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Scoreboard bench for mesi_isc_breq_arb: directed CPU FIFO contents with
// hand-computed broadcast entries, checked by a monitor on every strobe.
module tb_mesi_isc_breq_arb;

  localparam logic [1:0] T_NOP = 2'b00;
  localparam logic [1:0] T_WR  = 2'b01;
  localparam logic [1:0] T_RD  = 2'b10;

  typedef struct packed {
    logic [3:0]  rd;
    logic        wr;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [1:0]  cpu;
    logic [4:0]  id;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   breq_fifo_empty_array_i;
  logic [7:0]   breq_type_array_i;
  logic [127:0] breq_addr_array_i;
  logic         broad_fifo_full_i;
  logic [3:0]   breq_fifo_rd_array_o;
  logic         broad_fifo_wr_o;
  logic [1:0]   broad_type_o;
  logic [31:0]  broad_addr_o;
  logic [1:0]   broad_cpu_id_o;
  logic [4:0]   broad_id_o;

  mesi_isc_breq_arb dut (
    .clk                     (clk),
    .rst                     (rst),
    .breq_fifo_empty_array_i (breq_fifo_empty_array_i),
    .breq_type_array_i       (breq_type_array_i),
    .breq_addr_array_i       (breq_addr_array_i),
    .broad_fifo_full_i       (broad_fifo_full_i),
    .breq_fifo_rd_array_o    (breq_fifo_rd_array_o),
    .broad_fifo_wr_o         (broad_fifo_wr_o),
    .broad_type_o            (broad_type_o),
    .broad_addr_o            (broad_addr_o),
    .broad_cpu_id_o          (broad_cpu_id_o),
    .broad_id_o              (broad_id_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_strobe_cyc = -1;
  int          prev_strobe_cyc = 0;
  bit          spacing_on = 0;
  bit          have_prev = 0;
  exp_t        exp_q[$];
  logic [33:0] fq0[$];
  logic [33:0] fq1[$];
  logic [33:0] fq2[$];
  logic [33:0] fq3[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Monitor: every strobe must match the oldest expected entry.
  initial begin
    exp_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      if ((|breq_fifo_rd_array_o) || broad_fifo_wr_o) begin
        got = '{breq_fifo_rd_array_o, broad_fifo_wr_o, broad_type_o,
                broad_addr_o, broad_cpu_id_o, broad_id_o};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe cyc=%0d got=%h expected none", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL strobe cyc=%0d got rd=%b wr=%b type=%b addr=%h cpu=%0d id=%0d expected rd=%b wr=%b type=%b addr=%h cpu=%0d id=%0d",
                     cyc, got.rd, got.wr, got.typ, got.addr, got.cpu, got.id,
                     e.rd, e.wr, e.typ, e.addr, e.cpu, e.id);
          end
        end
        if (spacing_on && have_prev) begin
          n_vec++;
          if (cyc - prev_strobe_cyc != 2) begin
            n_err++;
            $display("FAIL spacing got=%0d expected=2", cyc - prev_strobe_cyc);
          end
        end
        have_prev = 1;
        prev_strobe_cyc = cyc;
        last_strobe_cyc = cyc;
      end
    end
  end

  function automatic void refresh();
    breq_fifo_empty_array_i = {fq3.size() == 0, fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
    breq_type_array_i = '0;
    breq_addr_array_i = '0;
    if (fq0.size() != 0) {breq_type_array_i[1:0], breq_addr_array_i[31:0]}   = fq0[0];
    if (fq1.size() != 0) {breq_type_array_i[3:2], breq_addr_array_i[63:32]}  = fq1[0];
    if (fq2.size() != 0) {breq_type_array_i[5:4], breq_addr_array_i[95:64]}  = fq2[0];
    if (fq3.size() != 0) {breq_type_array_i[7:6], breq_addr_array_i[127:96]} = fq3[0];
  endfunction

  task automatic load(input int cpu, input logic [1:0] t, input logic [31:0] a);
    case (cpu)
      0: fq0.push_back({t, a});
      1: fq1.push_back({t, a});
      2: fq2.push_back({t, a});
      default: fq3.push_back({t, a});
    endcase
    refresh();
  endtask

  task automatic expect_entry(input int cpu, input logic wr, input logic [1:0] t,
                              input logic [31:0] a, input logic [4:0] id);
    exp_t e;
    e.rd = 4'b0001 << cpu;
    e.wr = wr;
    e.typ = t;
    e.addr = a;
    e.cpu = 2'(cpu);
    e.id = id;
    exp_q.push_back(e);
  endtask

  // One clock: the emulated CPU FIFOs pop on the strobe, then inputs settle after the edge.
  task automatic step();
    @(negedge clk);
    if (breq_fifo_rd_array_o[0]) void'(fq0.pop_front());
    if (breq_fifo_rd_array_o[1]) void'(fq1.pop_front());
    if (breq_fifo_rd_array_o[2]) void'(fq2.pop_front());
    if (breq_fifo_rd_array_o[3]) void'(fq3.pop_front());
    refresh();
    @(posedge clk);
    #2;
  endtask

  function automatic int pending();
    return exp_q.size() + fq0.size() + fq1.size() + fq2.size() + fq3.size();
  endfunction

  task automatic drain(input int bound, input string name);
    int n = 0;
    while (pending() != 0 && n < bound) begin
      step();
      n++;
    end
    if (pending() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout pending=%0d expected 0 after %0d cycles", name, pending(), bound);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [45:0] got;
    got = {breq_fifo_rd_array_o, broad_fifo_wr_o, broad_type_o, broad_addr_o, broad_cpu_id_o, broad_id_o};
    n_vec++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL %s got=%h expected all outputs 0", name, got);
    end
  endtask

  task automatic do_reset();
    rst = 0;
    step();
    step();
    chk_zero("reset_outputs");
    rst = 1;
  endtask

  initial begin
    int c0;
    rst = 0;
    broad_fifo_full_i = 0;
    refresh();
    #2;

    // Single WR from CPU0 straight out of reset.
    do_reset();
    expect_entry(0, 1, T_WR, 32'h1000, 5'd0);
    load(0, T_WR, 32'h1000);
    drain(20, "single");

    // All four CPUs busy with RD: strict rotation, strobes every other cycle.
    do_reset();
    have_prev = 0;
    spacing_on = 1;
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < 4; n++) begin
        expect_entry(n, 1, T_RD, 32'h2000 + 32'(n * 16 + r), 5'(r * 4 + n));
        load(n, T_RD, 32'h2000 + 32'(n * 16 + r));
      end
    drain(40, "rotation");
    spacing_on = 0;

    // CPU2 WR held off by full; exactly one write once full drops.
    do_reset();
    broad_fifo_full_i = 1;
    load(2, T_WR, 32'hCAFE_0002);
    for (int i = 0; i < 5; i++) step();
    expect_entry(2, 1, T_WR, 32'hCAFE_0002, 5'd0);
    broad_fifo_full_i = 0;
    c0 = cyc;
    drain(20, "full_release");
    n_vec++;
    if (last_strobe_cyc != c0 + 1) begin
      n_err++;
      $display("FAIL full_release_cycle got=%0d expected=%0d", last_strobe_cyc, c0 + 1);
    end

    // NOP on CPU1 drains under full; CPU3 RD waits for full to drop.
    do_reset();
    expect_entry(0, 1, T_WR, 32'h0000_0100, 5'd0);
    load(0, T_WR, 32'h0000_0100);
    drain(20, "nop_setup");
    broad_fifo_full_i = 1;
    expect_entry(1, 0, T_NOP, 32'h0000_0044, 5'd1);
    load(1, T_NOP, 32'h0000_0044);
    load(3, T_RD, 32'h0000_3333);
    for (int i = 0; i < 6; i++) step();
    n_vec++;
    if (exp_q.size() != 0 || fq1.size() != 0 || fq3.size() != 1) begin
      n_err++;
      $display("FAIL nop_under_full got exp=%0d cpu1=%0d cpu3=%0d expected 0 0 1",
               exp_q.size(), fq1.size(), fq3.size());
    end
    expect_entry(3, 1, T_RD, 32'h0000_3333, 5'd1);
    broad_fifo_full_i = 0;
    drain(20, "nop_release");

    // 33 writes: broadcast id wraps from 31 to 0.
    do_reset();
    for (int i = 0; i < 33; i++) begin
      expect_entry(0, 1, T_WR, 32'h5000 + 32'(i), 5'(i));
      load(0, T_WR, 32'h5000 + 32'(i));
    end
    drain(120, "wrap");

    // Reset during ISSUE: id counter and pointer return to reset values.
    expect_entry(1, 1, T_RD, 32'h6000, 5'd1);
    load(1, T_RD, 32'h6000);
    step();
    rst = 0;
    step();
    chk_zero("rst_in_issue");
    rst = 1;
    expect_entry(0, 1, T_RD, 32'h7000, 5'd0);
    expect_entry(1, 1, T_WR, 32'h7001, 5'd1);
    load(1, T_WR, 32'h7001);
    load(0, T_RD, 32'h7000);
    drain(20, "after_reset");

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
